// File: rtl/link_if.sv
`default_nettype none
// ==== link_if : handshake/bus bundle between link_ctrl and its environment -- rev 1.0 ====
interface link_if #(
  parameter int BOARD_W = 162
);
  logic               move_commit;
  logic               manual_req;
  logic [BOARD_W-1:0] board_in;
  logic               tx_busy;
  logic               rx_ready;
  logic [BOARD_W-1:0] rx_data;
  logic               tx_trigger;
  logic [BOARD_W-1:0] tx_data;
  logic               rx_fwd;
  logic [BOARD_W-1:0] rx_fwd_data;
  logic               link_ok;
  logic               link_fail;
  logic               busy;
  logic [1:0]         retry_cnt;

  modport master (
    output move_commit, manual_req, board_in, tx_busy, rx_ready, rx_data,
    input  tx_trigger, tx_data, rx_fwd, rx_fwd_data, link_ok, link_fail, busy, retry_cnt
  );

  modport slave (
    input  move_commit, manual_req, board_in, tx_busy, rx_ready, rx_data,
    output tx_trigger, tx_data, rx_fwd, rx_fwd_data, link_ok, link_fail, busy, retry_cnt
  );
endinterface
`default_nettype wire

// File: rtl/link_ctrl.sv
`default_nettype none
// ==== link_ctrl : board-link sequencer/arbiter; echo/ack/retry enabled by LINK_RETRY_EN -- rev 1.0 ====
module link_ctrl #(
  parameter int BOARD_W        = 162,
  parameter int TIMEOUT_CYCLES = 6_500_000,
  parameter int MAX_RETRY      = 3,
  parameter int TX_START_GUARD = 16
) (
  input  logic  clk_in,
  input  logic  rst_in_n,
  link_if.slave bus
);
  localparam int GUARD_W = $clog2(TX_START_GUARD + 1);

`ifdef LINK_RETRY_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2, S_WAIT_ACK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2} state_t;
`endif

  state_t state, state_nx;

  logic               manual_q;
  logic               req_local;
  logic               local_pend;
  logic               seen_busy;
  logic [GUARD_W-1:0] guard_cnt;
  logic               tx_trigger_q;
  logic [BOARD_W-1:0] tx_q;
  logic               rx_fwd_q;
  logic [BOARD_W-1:0] rx_fwd_data_q;
  logic               link_ok_q;

  logic grant_local;
  logic send_done;
  logic fwd_now;
  logic ok_now;

`ifdef LINK_RETRY_EN
  logic               echo_pend;
  logic [BOARD_W-1:0] echo_buf;
  logic               is_echo;
  logic [TMR_W-1:0]   ack_tmr;
  logic [1:0]         retry_q;
  logic               link_fail_q;
  logic               grant_echo;
  logic               fail_now;
  logic               retry_now;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ (MAX_RETRY > 0);
`endif

  assign req_local = bus.move_commit | (bus.manual_req & ~manual_q);

  // Frame counts as sent once tx_busy has risen and fallen, or never rose within the guard window.
  always_comb begin
    send_done = 1'b0;
    if (state == S_SEND) begin
      if (seen_busy)
        send_done = !bus.tx_busy;
      else
        send_done = !bus.tx_busy && (guard_cnt == GUARD_W'(TX_START_GUARD - 1));
    end
  end

  always_comb begin
    state_nx    = state;
    grant_local = 1'b0;
    ok_now      = 1'b0;
    fwd_now     = bus.rx_ready;
`ifdef LINK_RETRY_EN
    grant_echo  = 1'b0;
    fail_now    = 1'b0;
    retry_now   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
`ifdef LINK_RETRY_EN
        if (echo_pend) begin
          grant_echo = 1'b1;
          state_nx   = S_LOAD;
        end else
`endif
        if (local_pend) begin
          grant_local = 1'b1;
          state_nx    = S_LOAD;
        end
      end
      S_LOAD: state_nx = S_SEND;
      S_SEND: begin
        if (send_done) begin
`ifdef LINK_RETRY_EN
          state_nx = is_echo ? S_IDLE : S_WAIT_ACK;
`else
          ok_now   = 1'b1;
          state_nx = S_IDLE;
`endif
        end
      end
`ifdef LINK_RETRY_EN
      S_WAIT_ACK: begin
        if (bus.rx_ready && (bus.rx_data == tx_q)) begin
          ok_now   = 1'b1;
          fwd_now  = 1'b0;
          state_nx = S_IDLE;
        end else if (ack_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_now = 1'b1;
            state_nx  = S_LOAD;
          end else begin
            fail_now = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      manual_q      <= 1'b0;
      local_pend    <= 1'b0;
      seen_busy     <= 1'b0;
      guard_cnt     <= '0;
      tx_trigger_q  <= 1'b0;
      tx_q          <= '0;
      rx_fwd_q      <= 1'b0;
      rx_fwd_data_q <= '0;
      link_ok_q     <= 1'b0;
    end else begin
      manual_q     <= bus.manual_req;
      // A new request wins over a same-cycle grant so it is never lost.
      local_pend   <= (local_pend & ~grant_local) | req_local;
      tx_trigger_q <= (state == S_LOAD);
      rx_fwd_q     <= fwd_now;
      link_ok_q    <= ok_now;
      if (fwd_now)
        rx_fwd_data_q <= bus.rx_data;
      if (state == S_LOAD) begin
`ifdef LINK_RETRY_EN
        tx_q <= is_echo ? echo_buf : bus.board_in;
`else
        tx_q <= bus.board_in;
`endif
        seen_busy <= 1'b0;
        guard_cnt <= '0;
      end else if (state == S_SEND) begin
        if (bus.tx_busy)
          seen_busy <= 1'b1;
        if (!seen_busy && !bus.tx_busy)
          guard_cnt <= guard_cnt + 1'b1;
      end
    end
  end

`ifdef LINK_RETRY_EN
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      echo_pend   <= 1'b0;
      echo_buf    <= '0;
      is_echo     <= 1'b0;
      ack_tmr     <= '0;
      retry_q     <= 2'd0;
      link_fail_q <= 1'b0;
    end else begin
      echo_pend   <= (echo_pend & ~grant_echo) | fwd_now;
      link_fail_q <= fail_now;
      if (fwd_now)
        echo_buf <= bus.rx_data;
      if (grant_echo)
        is_echo <= 1'b1;
      else if (grant_local)
        is_echo <= 1'b0;
      if (state != S_WAIT_ACK)
        ack_tmr <= '0;
      else
        ack_tmr <= ack_tmr + 1'b1;
      if (retry_now)
        retry_q <= retry_q + 2'd1;
      else if (ok_now || fail_now)
        retry_q <= 2'd0;
    end
  end

  assign bus.link_fail = link_fail_q;
  assign bus.retry_cnt = retry_q;
`else
  assign bus.link_fail = 1'b0;
  assign bus.retry_cnt = 2'd0;
`endif

  assign bus.tx_trigger  = tx_trigger_q;
  assign bus.tx_data     = tx_q;
  assign bus.rx_fwd      = rx_fwd_q;
  assign bus.rx_fwd_data = rx_fwd_data_q;
  assign bus.link_ok     = link_ok_q;
  assign bus.busy        = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_link_ctrl.sv
`default_nettype none
// ==== tb_link_ctrl : directed/randomized bench comparing link_ctrl event logs to a timing model -- rev 1.0 ====
module tb_link_ctrl;
  localparam int BW    = 162;
  localparam int TO    = 1200;
  localparam int GUARD = 16;
  localparam int MAXR  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  link_if #(.BOARD_W(BW)) bus ();

  link_ctrl #(
    .BOARD_W(BW), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR), .TX_START_GUARD(GUARD)
  ) dut (
    .clk_in(clk), .rst_in_n(rst_n), .bus(bus)
  );

  typedef struct { int cyc; logic [BW-1:0] dat; int rc; } ev_t;

  ev_t trig_q[$], fwd_q[$], exp_t[$], exp_f[$];
  int  ok_q[$], fail_q[$], exp_ok[$], exp_fail[$];
  int  cyc      = 0;
  int  busy_len = 0;
  int  tx_left  = 0;
  int  n_chk    = 0;
  int  n_pass   = 0;

  // Observed event log, sampled 1 time unit after each rising edge.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.tx_trigger) begin
        e.cyc = cyc; e.dat = bus.tx_data; e.rc = int'(bus.retry_cnt);
        trig_q.push_back(e);
      end
      if (bus.rx_fwd) begin
        e.cyc = cyc; e.dat = bus.rx_fwd_data; e.rc = 0;
        fwd_q.push_back(e);
      end
      if (bus.link_ok)   ok_q.push_back(cyc);
      if (bus.link_fail) fail_q.push_back(cyc);
    end
  end

  // Serializer stand-in: busy for busy_len cycles after each trigger.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n)                tx_left = 0;
      else if (bus.tx_trigger)   tx_left = busy_len;
      else if (tx_left > 0)      tx_left--;
      bus.tx_busy = (tx_left != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic chk_d(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [BW-1:0] rnd_board();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[BW-1:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic commit(input logic [BW-1:0] b);
    bus.board_in    = b;
    bus.move_commit = 1'b1;
    step(1);
    bus.move_commit = 1'b0;
  endtask

  task automatic rx(input logic [BW-1:0] d);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic exp_trig(input int c, input logic [BW-1:0] d, input int rc);
    ev_t e;
    e.cyc = c; e.dat = d; e.rc = rc;
    exp_t.push_back(e);
  endtask

  task automatic exp_fwd(input int c, input logic [BW-1:0] d);
    ev_t e;
    e.cyc = c; e.dat = d; e.rc = 0;
    exp_f.push_back(e);
  endtask

  task automatic check_logs(input string tag);
    chk_i({tag, " trig count"}, trig_q.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++) begin
      if (i < trig_q.size()) begin
        chk_i($sformatf("%s trig%0d cyc", tag, i), trig_q[i].cyc, exp_t[i].cyc);
        chk_d($sformatf("%s trig%0d data", tag, i), trig_q[i].dat, exp_t[i].dat);
        chk_i($sformatf("%s trig%0d retry_cnt", tag, i), trig_q[i].rc, exp_t[i].rc);
      end
    end
    chk_i({tag, " fwd count"}, fwd_q.size(), exp_f.size());
    for (int i = 0; i < exp_f.size(); i++) begin
      if (i < fwd_q.size()) begin
        chk_i($sformatf("%s fwd%0d cyc", tag, i), fwd_q[i].cyc, exp_f[i].cyc);
        chk_d($sformatf("%s fwd%0d data", tag, i), fwd_q[i].dat, exp_f[i].dat);
      end
    end
    chk_i({tag, " ok count"}, ok_q.size(), exp_ok.size());
    for (int i = 0; i < exp_ok.size(); i++)
      if (i < ok_q.size()) chk_i($sformatf("%s ok%0d cyc", tag, i), ok_q[i], exp_ok[i]);
    chk_i({tag, " fail count"}, fail_q.size(), exp_fail.size());
    for (int i = 0; i < exp_fail.size(); i++)
      if (i < fail_q.size()) chk_i($sformatf("%s fail%0d cyc", tag, i), fail_q[i], exp_fail[i]);
    chk_i({tag, " busy at end"}, int'(bus.busy), 0);
    chk_i({tag, " retry_cnt at end"}, int'(bus.retry_cnt), 0);
    trig_q.delete(); fwd_q.delete(); ok_q.delete(); fail_q.delete();
    exp_t.delete(); exp_f.delete(); exp_ok.delete(); exp_fail.delete();
  endtask

  initial begin
    logic [BW-1:0] a, b, c1, c2, d, e, f, g;
    int c0, t, l;

    bus.move_commit = 1'b0;
    bus.manual_req  = 1'b0;
    bus.board_in    = '0;
    bus.rx_ready    = 1'b0;
    bus.rx_data     = '0;

    // Reset state
    step(3);
    chk_i("reset ctrl outputs", int'({bus.tx_trigger, bus.rx_fwd, bus.link_ok,
                                       bus.link_fail, bus.busy, bus.retry_cnt}), 0);
    chk_d("reset tx_data", bus.tx_data, '0);
    chk_d("reset rx_fwd_data", bus.rx_fwd_data, '0);
    rst_n = 1'b1;
    step(3);
    trig_q.delete(); fwd_q.delete(); ok_q.delete(); fail_q.delete();

    // S1: local send, busy 200, echo 1000 cycles after trigger
    busy_len = 200;
    a  = rnd_board();
    c0 = cyc;
    commit(a);
    t  = c0 + 3;
    exp_trig(t, a, 0);
`ifdef LINK_RETRY_EN
    wait_until(t + 1000);
    rx(a);
    exp_ok.push_back(t + 1001);
`else
    exp_ok.push_back(t + busy_len + 1);
    wait_until(t + 1000);
    rx(a);
    exp_fwd(t + 1001, a);
`endif
    step(20);
    check_logs("s1");

    // S2: manual edge, no echo; board_in re-sampled on retries
    l        = $urandom_range(40, 5);
    busy_len = l;
    c1 = rnd_board();
    c2 = rnd_board();
    c0 = cyc;
    bus.board_in   = c1;
    bus.manual_req = 1'b1;
    step(4);
    bus.board_in = c2;
    t = c0 + 3;
`ifdef LINK_RETRY_EN
    for (int k = 0; k <= MAXR; k++) begin
      exp_trig(t, (k == 0) ? c1 : c2, k);
      if (k < MAXR) t = t + l + TO + 2;
    end
    exp_fail.push_back(t + l + TO + 1);
    wait_until(t + l + TO + 20);
`else
    exp_trig(t, c1, 0);
    exp_ok.push_back(t + l + 1);
    wait_until(t + l + 40);
`endif
    bus.manual_req = 1'b0;
    step(5);
    check_logs("s2");

    // S3: unsolicited remote frame while idle
    l        = $urandom_range(60, 10);
    busy_len = l;
    b  = rnd_board();
    c0 = cyc;
    rx(b);
    exp_fwd(c0 + 1, b);
`ifdef LINK_RETRY_EN
    exp_trig(c0 + 3, b, 0);
`endif
    step(l + 40);
    check_logs("s3");

    // S4: foreign frame during ack wait, local request queued during SEND
    busy_len = 30;
    a = rnd_board();
    b = rnd_board();
    d = rnd_board();
    b[0] = ~a[0];
    c0 = cyc;
    commit(a);
    t = c0 + 3;
    wait_until(t + 10);
    commit(d);
    wait_until(t + 60);
    rx(b);
    wait_until(t + 80);
    rx(a);
    wait_until(t + 200);
    rx(d);
`ifdef LINK_RETRY_EN
    exp_trig(t, a, 0);
    exp_trig(t + 83, b, 0);
    exp_trig(t + 116, d, 0);
    exp_fwd(t + 61, b);
    exp_ok.push_back(t + 81);
    exp_ok.push_back(t + 201);
`else
    exp_trig(t, a, 0);
    exp_trig(t + 33, d, 0);
    exp_fwd(t + 61, b);
    exp_fwd(t + 81, a);
    exp_fwd(t + 201, d);
    exp_ok.push_back(t + 31);
    exp_ok.push_back(t + 64);
`endif
    step(20);
    check_logs("s4");

    // S5: tx_busy never rises; SEND ends on the guard window
    busy_len = 0;
    e  = rnd_board();
    c0 = cyc;
    commit(e);
    t  = c0 + 3;
    exp_trig(t, e, 0);
    wait_until(t + GUARD);
    rx(e);
`ifdef LINK_RETRY_EN
    exp_ok.push_back(t + GUARD + 1);
`else
    exp_ok.push_back(t + GUARD);
    exp_fwd(t + GUARD + 1, e);
`endif
    step(10);
    check_logs("s5");

    // S6: asynchronous reset mid-SEND with a request pending
    busy_len = 100;
    f  = rnd_board();
    g  = rnd_board();
    c0 = cyc;
    commit(f);
    t  = c0 + 3;
    exp_trig(t, f, 0);
    wait_until(t + 8);
    commit(g);
    wait_until(t + 30);
    #2 rst_n = 1'b0;
    #1;
    chk_i("s6 async ctrl outputs", int'({bus.tx_trigger, bus.rx_fwd, bus.link_ok,
                                          bus.link_fail, bus.busy, bus.retry_cnt}), 0);
    chk_d("s6 async tx_data", bus.tx_data, '0);
    step(2);
    rst_n = 1'b1;
    step(300);
    check_logs("s6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
